// File: rtl/cmd_line_parser.sv
// cmd_line_parser: collects ASCII lines from a show-ahead RX FIFO and decodes one of five command words plus NUM_PARAMS hex bytes.
// Optional byte echo port via macro CMD_LINE_PARSER_ECHO_EN. Result two cycles after the terminator pop; no pops while a command waits.
module cmd_line_parser #(
    parameter int MAX_CMD_LENGTH = 30,
    parameter int NUM_PARAMS     = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rx_fifo_empty,
    input  logic [7:0]                rx_fifo_data_out,
    output logic                      rx_fifo_read_en,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [2:0]                cmd_type,
    output logic [8*NUM_PARAMS-1:0]   cmd_params,
    output logic                      cmd_error
`ifdef CMD_LINE_PARSER_ECHO_EN
    ,
    output logic [7:0]                echo_data,
    output logic                      echo_write_en
`endif
);
    localparam int LEN_W   = $clog2(MAX_CMD_LENGTH + 1);
    localparam int MIN_LEN = 11 + 2 * NUM_PARAMS;

    typedef enum logic [1:0] {COLLECT, PARSE, HOLD, DISCARD} state_t;

    state_t                  state;
    logic [LEN_W-1:0]        length;
    logic [7:0]              line_buf [MAX_CMD_LENGTH];
    logic                    pop_q;
    logic                    is_term;
    logic [87:0]             word;
    logic [2:0]              word_type;
    logic [4:0]              nib_hi [NUM_PARAMS];
    logic [4:0]              nib_lo [NUM_PARAMS];
    logic                    hex_ok;
    logic [8*NUM_PARAMS-1:0] params;
    logic                    parse_ok;

    // {valid, value}; the low nibble of 'A'..'F' / 'a'..'f' plus 9 gives 10..15
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    assign rx_fifo_read_en = reset_n && (state == COLLECT || state == DISCARD)
                             && !rx_fifo_empty && !pop_q;
    assign is_term = (rx_fifo_data_out == 8'h0D) || (rx_fifo_data_out == 8'h0A);

    always_comb begin
        word = '0;
        for (int i = 0; i < 11; i++) word[8*(10-i) +: 8] = line_buf[i];
        case (word)
            "pb_i_write,": word_type = 3'd1;
            "pb_i__read,": word_type = 3'd2;
            "pb_adc4_16,": word_type = 3'd3;
            "pb_adc4_08,": word_type = 3'd4;
            "test______,": word_type = 3'd5;
            default:       word_type = 3'd0;
        endcase
        hex_ok = 1'b1;
        params = '0;
        for (int p = 0; p < NUM_PARAMS; p++) begin
            nib_hi[p] = hex_nib(line_buf[11 + 2*p]);
            nib_lo[p] = hex_nib(line_buf[12 + 2*p]);
            hex_ok    = hex_ok & nib_hi[p][4] & nib_lo[p][4];
            params[8*p +: 8] = {nib_hi[p][3:0], nib_lo[p][3:0]};
        end
        parse_ok = (word_type != 3'd0) && hex_ok && (length >= LEN_W'(MIN_LEN));
    end

    // Line storage needs no reset: length gates every read of stale bytes
    always_ff @(posedge clock) begin
        if (state == COLLECT && rx_fifo_read_en && !is_term && length < LEN_W'(MAX_CMD_LENGTH))
            line_buf[length] <= rx_fifo_data_out;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= COLLECT;
            length     <= '0;
            pop_q      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_type   <= 3'd0;
            cmd_params <= '0;
            cmd_error  <= 1'b0;
        end else begin
            pop_q     <= rx_fifo_read_en;
            cmd_error <= 1'b0;
            case (state)
                COLLECT: begin
                    if (rx_fifo_read_en) begin
                        if (is_term) begin
                            if (length != '0) state <= PARSE;
                        end else if (length == LEN_W'(MAX_CMD_LENGTH)) begin
                            state <= DISCARD;
                        end else begin
                            length <= length + 1'b1;
                        end
                    end
                end
                PARSE: begin
                    length <= '0;
                    if (parse_ok) begin
                        state      <= HOLD;
                        cmd_valid  <= 1'b1;
                        cmd_type   <= word_type;
                        cmd_params <= params;
                    end else begin
                        state     <= COLLECT;
                        cmd_error <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cmd_ready) begin
                        state      <= COLLECT;
                        cmd_valid  <= 1'b0;
                        cmd_type   <= 3'd0;
                        cmd_params <= '0;
                    end
                end
                DISCARD: begin
                    if (rx_fifo_read_en && is_term) begin
                        state     <= COLLECT;
                        length    <= '0;
                        cmd_error <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef CMD_LINE_PARSER_ECHO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_data     <= 8'd0;
            echo_write_en <= 1'b0;
        end else begin
            echo_write_en <= rx_fifo_read_en;
            if (rx_fifo_read_en) echo_data <= rx_fifo_data_out;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_line_parser.sv
// Bench for cmd_line_parser: directed and random lines pushed through a modelled show-ahead FIFO,
// results scored against a string-level reference model of the command grammar.
module tb_cmd_line_parser;
    localparam int MAXL = 30;
    localparam int NP   = 5;

    typedef struct {
        logic        err;
        logic [2:0]  typ;
        logic [39:0] prm;
        int          lat;
    } outcome_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_fifo_empty = 1'b1;
    logic [7:0]  rx_fifo_data_out = 8'd0;
    logic        rx_fifo_read_en;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_type;
    logic [39:0] cmd_params;
    logic        cmd_error;
`ifdef CMD_LINE_PARSER_ECHO_EN
    logic [7:0]  echo_data;
    logic        echo_write_en;
`endif

    cmd_line_parser #(.MAX_CMD_LENGTH(MAXL), .NUM_PARAMS(NP)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_data_out(rx_fifo_data_out),
        .rx_fifo_read_en(rx_fifo_read_en),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_params(cmd_params),
        .cmd_error(cmd_error)
`ifdef CMD_LINE_PARSER_ECHO_EN
        ,
        .echo_data(echo_data),
        .echo_write_en(echo_write_en)
`endif
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [7:0]  fq[$];
    outcome_t    exp_q[$];
    string       words[5] = '{"pb_i_write,", "pb_i__read,", "pb_adc4_16,", "pb_adc4_08,", "test______,"};
    string       hexchars = "0123456789abcdefABCDEF";
    logic        pend = 1'b0;
    logic [7:0]  fifo_b;
    int          seen = 0;
    int          line_end_cyc = 0;
    logic        force_low = 1'b0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
    logic [2:0]  prev_type = 3'd0;
    logic [39:0] prev_params = 40'd0;
    outcome_t    mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int hexv(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Reference: the whole line as a string, judged by the command grammar
    function automatic outcome_t model(input string s);
        outcome_t o;
        int hi, lo;
        o.err = 1'b1; o.typ = 3'd0; o.prm = '0; o.lat = 2;
        if (s.len() > MAXL) begin o.lat = 0; return o; end
        if (s.len() < 11 + 2*NP) return o;
        for (int w = 0; w < 5; w++) if (s.substr(0, 10) == words[w]) o.typ = 3'(w + 1);
        if (o.typ == 3'd0) return o;
        for (int p = 0; p < NP; p++) begin
            hi = hexv(s[11 + 2*p]);
            lo = hexv(s[12 + 2*p]);
            if (hi < 0 || lo < 0) begin o.typ = 3'd0; return o; end
            o.prm[8*p +: 8] = 8'(hi * 16 + lo);
        end
        o.err = 1'b0;
        return o;
    endfunction

    // term: 0 CR, 1 LF, 2 CR LF
    task automatic push_line(input string s, input int term, input bit expect_out);
        for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
        if (term != 1) fq.push_back(8'h0D);
        if (term != 0) fq.push_back(8'h0A);
        if (expect_out && s.len() > 0) exp_q.push_back(model(s));
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < 8000) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        chk("drain_pending", 64'(exp_q.size()), 0);
    endtask

    always @(posedge clock) cyc++;

    // Show-ahead FIFO: pops the head when read_en was high across the last rising edge
    always begin
        @(negedge clock);
        if (pend && fq.size() > 0) begin
            fifo_b = fq.pop_front();
            if (fifo_b == 8'h0D || fifo_b == 8'h0A) begin
                if (seen > 0) line_end_cyc = cyc - 1;
                seen = 0;
            end else begin
                seen++;
            end
        end
        rx_fifo_empty    = (fq.size() == 0);
        rx_fifo_data_out = (fq.size() == 0) ? 8'd0 : fq[0];
        #1;
        pend = rx_fifo_read_en;
        if (!reset_n) seen = 0;
    end

    always begin
        @(negedge clock);
        cmd_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always begin
        @(negedge clock);
        #2;
        if (reset_n) begin
            if (cmd_error) begin
                if (exp_q.size() == 0) chk("unexpected_error", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("error_expected", mon_e.err, 1);
                    if (mon_e.lat != 0) chk("error_latency", 64'(cyc - line_end_cyc), 2);
                end
                chk("error_without_valid", cmd_valid, 0);
                chk("error_one_cycle", prev_err, 0);
            end
            if (cmd_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    chk("valid_expected", exp_q[0].err, 0);
                    chk("valid_latency", 64'(cyc - line_end_cyc), 2);
                end
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", cmd_valid, 1);
                chk("hold_type", cmd_type, prev_type);
                chk("hold_params", cmd_params, prev_params);
            end
            if (cmd_valid) chk("no_pop_in_hold", rx_fifo_read_en, 0);
            else chk("idle_outputs_zero", {cmd_type, cmd_params}, 0);
            if (cmd_valid && cmd_ready && exp_q.size() > 0 && !exp_q[0].err) begin
                mon_e = exp_q.pop_front();
                chk("cmd_type", cmd_type, mon_e.typ);
                chk("cmd_params", cmd_params, mon_e.prm);
            end
            prev_valid  = cmd_valid;
            prev_ready  = cmd_ready;
            prev_type   = cmd_type;
            prev_params = cmd_params;
            prev_err    = cmd_error;
        end else begin
            prev_valid = 1'b0;
            prev_err   = 1'b0;
        end
    end

    task automatic rand_line();
        string s;
        int kind;
        kind = $urandom_range(0, 6);
        s = words[$urandom_range(0, 4)];
        for (int i = 0; i < 2*NP; i++) s = $sformatf("%s%c", s, hexchars[$urandom_range(0, 21)]);
        case (kind)
            1: s.putc($urandom_range(0, 10), 8'h23);
            2: s.putc(11 + $urandom_range(0, 2*NP - 1), ($urandom_range(0, 1) != 0) ? 8'h2F : 8'h67);
            3: s = s.substr(0, $urandom_range(0, 19));
            4: begin
                int extra = $urandom_range(1, MAXL - 21);
                for (int i = 0; i < extra; i++) s = $sformatf("%s%c", s, 8'($urandom_range(33, 126)));
            end
            5: begin
                int extra = $urandom_range(MAXL - 20, MAXL - 13);
                for (int i = 0; i < extra; i++) s = $sformatf("%s%c", s, 8'($urandom_range(33, 126)));
            end
            6: s = "";
            default: ;
        endcase
        push_line(s, $urandom_range(0, 2), 1'b1);
    endtask

    initial begin
        string a35;
        int n;
        repeat (3) @(negedge clock);
        chk("reset_read_en", rx_fifo_read_en, 0);
        chk("reset_cmd_valid", cmd_valid, 0);
        chk("reset_cmd_type", cmd_type, 0);
        chk("reset_cmd_params", cmd_params, 0);
        chk("reset_cmd_error", cmd_error, 0);
        reset_n = 1'b1;

        push_line("pb_i_write,0A1b2C3d4E", 2, 1'b1);
        drain();

        force_low = 1'b1;
        push_line("pb_adc4_08,0000000001", 0, 1'b1);
        push_line("test______,0123456789", 0, 1'b1);
        n = 0;
        while (!cmd_valid && n < 200) begin @(negedge clock); n++; end
        chk("backpressure_valid", cmd_valid, 1);
        repeat (22) @(negedge clock);
        chk("backpressure_fifo_waits", 64'(fq.size() > 0), 1);
        chk("backpressure_type", cmd_type, 4);
        force_low = 1'b0;
        drain();

        push_line("pb_xxx____,0000000000", 0, 1'b1);
        push_line("pb_i__read,12345G7890", 0, 1'b1);
        push_line("test______,FFFFFFFFFF", 0, 1'b1);
        a35 = "";
        for (int i = 0; i < 35; i++) a35 = {a35, "A"};
        push_line(a35, 0, 1'b1);
        push_line("pb_adc4_16,00112233aa", 2, 1'b1);
        drain();

        push_line("pb_i_wri", 0, 1'b0);
        void'(fq.pop_back());
        n = 0;
        while (fq.size() != 0 && n < 100) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midline_reset_read_en", rx_fifo_read_en, 0);
        chk("midline_reset_valid", cmd_valid, 0);
        chk("midline_reset_error", cmd_error, 0);
        @(negedge clock);
        reset_n = 1'b1;
        push_line("pb_i__read,DEADbeef01", 0, 1'b1);
        drain();

        for (int k = 0; k < 40; k++) rand_line();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmd_line_parser.md
CMD_LINE_PARSER -- requirements
Module: cmd_line_parser

Interface
REQ-001 SHALL have parameter MAX_CMD_LENGTH, default 30, maximum characters per line excluding terminator.
REQ-002 SHALL have parameter NUM_PARAMS, default 5, number of hex parameter bytes per command.
REQ-003 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_fifo_empty, input, 1, high when the UART RX FIFO holds no byte.
REQ-006 SHALL have port rx_fifo_data_out, input, 8, show-ahead head byte, valid while rx_fifo_empty is low.
REQ-007 SHALL have port rx_fifo_read_en, output, 1, one-cycle pop strobe to the RX FIFO.
REQ-008 SHALL have port cmd_valid, output, 1, decoded command available.
REQ-009 SHALL have port cmd_ready, input, 1, consumer accepts the command.
REQ-010 SHALL have port cmd_type, output, 3, command code: 1 "pb_i_write,", 2 "pb_i__read,", 3 "pb_adc4_16,", 4 "pb_adc4_08,", 5 "test______,".
REQ-011 SHALL have port cmd_params, output, 8*NUM_PARAMS, parameter byte 0 in bits [7:0], byte i in bits [8i+7:8i].
REQ-012 SHALL have port cmd_error, output, 1, one-cycle pulse on a rejected line.

Function
REQ-013 SHALL implement states COLLECT, PARSE, HOLD, DISCARD; COLLECT after reset.
REQ-014 COLLECT: when rx_fifo_empty low and no pop in the previous cycle, SHALL assert rx_fifo_read_en and capture rx_fifo_data_out in the same cycle; at most one pop every two cycles.
REQ-015 Byte 0x0D or 0x0A SHALL terminate the line; a terminator with line length 0 SHALL be dropped silently, so CR LF yields one command.
REQ-016 Non-terminator bytes SHALL be stored at index length and length incremented.
REQ-017 Storing byte MAX_CMD_LENGTH+1 SHALL enter DISCARD: pop and drop bytes until a terminator, then pulse cmd_error and return to COLLECT with length 0.
REQ-018 Terminator with length>0 consumed in cycle T SHALL enter PARSE at T+1; at T+2 either cmd_valid rises (HOLD) or cmd_error pulses (COLLECT).
REQ-019 PARSE SHALL match chars 0..10 against the five 11-char words in REQ-010 (case-sensitive).
REQ-020 PARSE SHALL convert chars 11..(10+2*NUM_PARAMS), high nibble first; '0'-'9','A'-'F','a'-'f' accepted.
REQ-021 PARSE SHALL reject when: no word matches, length < 11+2*NUM_PARAMS, or any parameter char is not hex; characters beyond the parameters SHALL be ignored.
REQ-022 HOLD: cmd_valid, cmd_type and cmd_params SHALL stay stable until the cycle cmd_valid and cmd_ready are both high; then return to COLLECT with length 0 the next cycle.
REQ-023 No FIFO pop SHALL occur in PARSE or HOLD (backpressure).
REQ-024 cmd_type SHALL be 0 and cmd_params 0 whenever cmd_valid is low.

Reset
REQ-025 reset_n low SHALL immediately force: rx_fifo_read_en 0, cmd_valid 0, cmd_type 0, cmd_params 0, cmd_error 0, length 0, state COLLECT.
REQ-026 Reset mid-line or in HOLD SHALL discard the partial line or pending command; no error pulse.

Configuration
REQ-027 With macro CMD_LINE_PARSER_ECHO_EN defined, SHALL add outputs echo_data (8) and echo_write_en (1); each popped byte, terminators included, SHALL be presented on echo_data with echo_write_en high for one cycle in the cycle after its pop, reset value 0.
REQ-028 Without CMD_LINE_PARSER_ECHO_EN the echo ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 "pb_i_write,0A1b2C3d4E" CR LF, cmd_ready=1 -> one cmd_valid cycle, cmd_type=1, cmd_params=0x4E3D2C1B0A, no cmd_error.
REQ-030 "pb_adc4_08,0000000001" CR, cmd_ready low 20 cycles -> cmd_type=4 held stable 20+ cycles, rx_fifo_read_en stays 0 while next line waits in FIFO.
REQ-031 "pb_xxx____,0000000000" CR -> cmd_error one pulse at T+2, cmd_valid never high.
REQ-032 "pb_i__read,12345G7890" CR -> cmd_error; following "test______,FFFFFFFFFF" CR -> cmd_type=5, cmd_params=0xFFFFFFFFFF.
REQ-033 35 'A' then CR -> exactly one cmd_error after CR pop, all 36 bytes popped; next valid line decodes normally.
REQ-034 reset_n low for 1 cycle after 8 chars of a line -> no output; next complete line decodes with correct type and params.
